// File: rtl/sentry_pc_rebuild.sv
// Rebuilds per-lane PC and sequence numbers for committed-instruction trace
// bundles and hands them to the icache request stage through a 2-entry FIFO.
module sentry_pc_rebuild #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned SEQ_W = 32,
   parameter logic [ADDR_W-1:0] START_PC = 32'h0000_0000,
   parameter int unsigned INST_BYTES = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [WIDTH-1:0]          in_lane_valid,
   input  logic [WIDTH-1:0]          in_jump,
   input  logic [WIDTH*DATA_W-1:0]   in_result,
   input  logic                      resync_valid,
   input  logic [ADDR_W-1:0]         resync_pc,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [WIDTH-1:0]          out_lane_valid,
   output logic [WIDTH*ADDR_W-1:0]   out_pc,
   output logic [WIDTH*DATA_W-1:0]   out_result,
   output logic [WIDTH*SEQ_W-1:0]    out_seq,
   output logic                      err_mask
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   logic                    active;
   logic [ADDR_W-1:0]       pc;
   logic [SEQ_W-1:0]        seq;
   logic [1:0]              count;
   logic                    wr_ptr;
   logic                    rd_ptr;

   logic [WIDTH-1:0]        m_lv  [2];
   logic [WIDTH*ADDR_W-1:0] m_pc  [2];
   logic [WIDTH*DATA_W-1:0] m_res [2];
   logic [WIDTH*SEQ_W-1:0]  m_seq [2];

   logic [CW-1:0]           n;
   logic                    run;
   logic                    gap;
   logic [ADDR_W-1:0]       cur;
   logic [WIDTH-1:0]        push_lv;
   logic [WIDTH*ADDR_W-1:0] push_pc;
   logic [WIDTH*DATA_W-1:0] push_res;
   logic [WIDTH*SEQ_W-1:0]  push_seq;
   logic                    accept;
   logic                    push;
   logic                    pop;

   // Lane PCs are built as a running value: a jump replaces it with the
   // target, otherwise it advances by one instruction; its final value is next_pc.
   always_comb begin
      run      = 1'b1;
      gap      = 1'b0;
      n        = '0;
      cur      = pc;
      push_lv  = '0;
      push_pc  = '0;
      push_res = '0;
      push_seq = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (!in_lane_valid[i]) begin
            run = 1'b0;
         end else if (run) begin
            n                             = n + CW'(1);
            push_lv[i]                    = 1'b1;
            push_pc[i*ADDR_W +: ADDR_W]   = cur;
            push_res[i*DATA_W +: DATA_W]  = in_result[i*DATA_W +: DATA_W];
            push_seq[i*SEQ_W +: SEQ_W]    = seq + SEQ_W'(i);
            cur = in_jump[i] ? in_result[i*DATA_W +: ADDR_W] : cur + ADDR_W'(INST_BYTES);
         end else begin
            gap = 1'b1;
         end
      end
   end

   assign in_ready  = active && (count < 2'd2);
   assign out_valid = (count != 2'd0);
   assign accept    = in_valid && in_ready;
   assign push      = accept && (n != '0);
   assign pop       = out_valid && out_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         active   <= 1'b0;
         pc       <= START_PC;
         seq      <= SEQ_W'(1);
         count    <= '0;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         err_mask <= 1'b0;
         for (int unsigned e = 0; e < 2; e++) begin
            m_lv[e]  <= '0;
            m_pc[e]  <= '0;
            m_res[e] <= '0;
            m_seq[e] <= '0;
         end
      end else begin
         active <= 1'b1;
         if (accept && gap) err_mask <= 1'b1;
         if (push) begin
            m_lv[wr_ptr]  <= push_lv;
            m_pc[wr_ptr]  <= push_pc;
            m_res[wr_ptr] <= push_res;
            m_seq[wr_ptr] <= push_seq;
            wr_ptr        <= ~wr_ptr;
            pc            <= cur;
            seq           <= seq + SEQ_W'(n);
         end
         if (resync_valid) pc <= resync_pc;
         if (pop) rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

   assign out_lane_valid = out_valid ? m_lv[rd_ptr]  : '0;
   assign out_pc         = out_valid ? m_pc[rd_ptr]  : '0;
   assign out_result     = out_valid ? m_res[rd_ptr] : '0;
   assign out_seq        = out_valid ? m_seq[rd_ptr] : '0;

endmodule

// File: tb/tb_sentry_pc_rebuild.sv
// Directed bench for sentry_pc_rebuild (WIDTH=4, START_PC=0x1000).
module tb_sentry_pc_rebuild;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [3:0]    in_lane_valid = '0;
   logic [3:0]    in_jump = '0;
   logic [127:0]  in_result = '0;
   logic          resync_valid = 1'b0;
   logic [31:0]   resync_pc = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [3:0]    out_lane_valid;
   logic [127:0]  out_pc;
   logic [127:0]  out_result;
   logic [127:0]  out_seq;
   logic          err_mask;

   int checks = 0;
   int failures = 0;

   sentry_pc_rebuild #(
      .WIDTH(4), .ADDR_W(32), .DATA_W(32), .SEQ_W(32),
      .START_PC(32'h0000_1000), .INST_BYTES(4)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_lane_valid(in_lane_valid), .in_jump(in_jump), .in_result(in_result),
      .resync_valid(resync_valid), .resync_pc(resync_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_lane_valid(out_lane_valid), .out_pc(out_pc),
      .out_result(out_result), .out_seq(out_seq), .err_mask(err_mask)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] p4(input logic [31:0] l0, l1, l2, l3);
      return {l3, l2, l1, l0};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [3:0] m, input logic [3:0] j, input logic [127:0] r);
      in_valid      = 1'b1;
      in_lane_valid = m;
      in_jump       = j;
      in_result     = r;
      cyc();
      in_valid      = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #1;
      check("rst_out_valid", 128'(out_valid), 128'(0));
      check("rst_in_ready", 128'(in_ready), 128'(0));
      check("rst_err", 128'(err_mask), 128'(0));
      check("rst_pc", out_pc, '0);
      check("rst_lv", 128'(out_lane_valid), 128'(0));
      cyc();
      cyc();
      check("rst_hold_ready", 128'(in_ready), 128'(0));
      @(negedge clk) rst = 1'b1;
      cyc();
      check("ready_after_rst", 128'(in_ready), 128'(1));

      // sequential bundles
      send(4'b1111, 4'b0000, '0);
      check("seq1_pc", out_pc, p4(32'h1000, 32'h1004, 32'h1008, 32'h100C));
      check("seq1_seq", out_seq, p4(1, 2, 3, 4));
      check("seq1_lv", 128'(out_lane_valid), 128'hF);
      send(4'b1111, 4'b0000, '0);
      check("seq2_pc", out_pc, p4(32'h1010, 32'h1014, 32'h1018, 32'h101C));
      check("seq2_seq", out_seq, p4(5, 6, 7, 8));

      // jumps on lanes 0 and 2
      send(4'b1111, 4'b0101, p4(32'h2000, 0, 32'h3000, 0));
      check("jmp_pc", out_pc, p4(32'h1020, 32'h2000, 32'h2004, 32'h3000));
      check("jmp_res", out_result, p4(32'h2000, 0, 32'h3000, 0));
      check("jmp_seq", out_seq, p4(9, 10, 11, 12));

      // partial mask, jump on lane 1, upper lanes carry junk
      send(4'b0011, 4'b0010, p4(32'hAAAA, 32'h4000, 32'h5555, 32'h5555));
      check("part_lv", 128'(out_lane_valid), 128'h3);
      check("part_pc", out_pc, p4(32'h3004, 32'h3008, 0, 0));
      check("part_res", out_result, p4(32'hAAAA, 32'h4000, 0, 0));
      check("part_seq", out_seq, p4(13, 14, 0, 0));
      check("part_err", 128'(err_mask), 128'(0));

      // gapped mask keeps only lane 0
      send(4'b0101, 4'b0000, '0);
      check("gap_lv", 128'(out_lane_valid), 128'h1);
      check("gap_pc", out_pc, p4(32'h4000, 0, 0, 0));
      check("gap_seq", out_seq, p4(15, 0, 0, 0));
      check("gap_err", 128'(err_mask), 128'(1));

      // empty-lane bundle: consumed, nothing pushed, no state change
      send(4'b0000, 4'b0000, '0);
      check("zero_nopush", 128'(out_valid), 128'(0));
      send(4'b0001, 4'b0000, '0);
      check("zero_after_pc", out_pc, p4(32'h4004, 0, 0, 0));
      check("zero_after_seq", out_seq, p4(16, 0, 0, 0));
      cyc();
      check("drained", 128'(out_valid), 128'(0));

      // back-pressure
      out_ready = 1'b0;
      send(4'b1111, 4'b0000, '0);
      check("bp_a_ready", 128'(in_ready), 128'(1));
      check("bp_a_head", out_pc, p4(32'h4008, 32'h400C, 32'h4010, 32'h4014));
      send(4'b1111, 4'b0000, '0);
      check("bp_full_ready", 128'(in_ready), 128'(0));
      in_valid = 1'b1;
      cyc();
      check("bp_stall_head", out_pc, p4(32'h4008, 32'h400C, 32'h4010, 32'h4014));
      check("bp_stall_ready", 128'(in_ready), 128'(0));
      out_ready = 1'b1;
      cyc();
      check("bp_pop1_head", out_pc, p4(32'h4018, 32'h401C, 32'h4020, 32'h4024));
      check("bp_pop1_ready", 128'(in_ready), 128'(1));
      cyc();
      in_valid = 1'b0;
      check("bp_c_head", out_pc, p4(32'h4028, 32'h402C, 32'h4030, 32'h4034));
      check("bp_c_seq", out_seq, p4(25, 26, 27, 28));
      cyc();
      check("bp_empty", 128'(out_valid), 128'(0));

      // resync: bundle uses old pc, next bundle starts at resync_pc
      resync_valid = 1'b1;
      resync_pc    = 32'h1000;
      cyc();
      resync_pc    = 32'h8000;
      send(4'b1111, 4'b0000, '0);
      resync_valid = 1'b0;
      check("rs_pc", out_pc, p4(32'h1000, 32'h1004, 32'h1008, 32'h100C));
      check("rs_seq", out_seq, p4(29, 30, 31, 32));
      send(4'b1111, 4'b0000, '0);
      check("rs_next_pc", out_pc, p4(32'h8000, 32'h8004, 32'h8008, 32'h800C));
      check("rs_next_seq", out_seq, p4(33, 34, 35, 36));

      // PC wrap
      resync_valid = 1'b1;
      resync_pc    = 32'hFFFF_FFF8;
      cyc();
      resync_valid = 1'b0;
      send(4'b1111, 4'b0000, '0);
      check("wrap_pc", out_pc, p4(32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4));
      cyc();

      // mid-operation reset with a full FIFO
      out_ready = 1'b0;
      send(4'b1111, 4'b0000, '0);
      send(4'b1111, 4'b0000, '0);
      check("mr_full", 128'(in_ready), 128'(0));
      check("mr_head", out_pc, p4(32'h8, 32'hC, 32'h10, 32'h14));
      #2 rst = 1'b0;
      #1;
      check("mr_out_valid", 128'(out_valid), 128'(0));
      check("mr_in_ready", 128'(in_ready), 128'(0));
      check("mr_err", 128'(err_mask), 128'(0));
      out_ready = 1'b1;
      @(negedge clk) rst = 1'b1;
      cyc();
      check("mr_ready_back", 128'(in_ready), 128'(1));
      send(4'b1111, 4'b0000, '0);
      check("mr_pc", out_pc, p4(32'h1000, 32'h1004, 32'h1008, 32'h100C));
      check("mr_seq", out_seq, p4(1, 2, 3, 4));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sentry_pc_rebuild.md
# sentry_pc_rebuild

Parametrised successor to the fixed four-lane jump-result PC reconstruction stage in the sentry control path. Consumes bundles of up to `WIDTH` committed-instruction jump results from the trace FIFO and rebuilds each instruction's PC and sequence number. Each bundle may be partial, with a lane-valid mask. Reconstructed bundles go to the icache request stage through a 2-entry output buffer with a true valid/ready handshake, replacing the almost-full back-pressure scheme. A resync port reloads the PC at run time.

## Interface
- `WIDTH`, 4: lanes per bundle (1..8).
- `ADDR_W`, 32: PC width.
- `DATA_W`, 32: result width (`DATA_W >= ADDR_W`; the low `ADDR_W` bits form the jump target).
- `SEQ_W`, 32: sequence-number width.
- `START_PC`, 32'h0000_0000: PC after reset.
- `INST_BYTES`, 4: fixed instruction size.
- `clk`, input, 1: single clock; all state is rising-edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: a trace bundle is present.
- `in_ready`, output, 1: the block accepts a bundle this cycle.
- `in_lane_valid`, input, WIDTH: per-lane valid mask.
- `in_jump`, input, WIDTH: lane i redirected control flow.
- `in_result`, input, WIDTH*DATA_W: per-lane result; lane i occupies bits `[i*DATA_W +: DATA_W]`.
- `resync_valid`, input, 1: load a new PC.
- `resync_pc`, input, ADDR_W: the new PC.
- `out_valid`, output, 1: the head entry is valid.
- `out_ready`, input, 1: the consumer takes the head entry.
- `out_lane_valid`, output, WIDTH: lanes of the head entry.
- `out_pc`, output, WIDTH*ADDR_W: per-lane reconstructed PC.
- `out_result`, output, WIDTH*DATA_W: per-lane result, passed through.
- `out_seq`, output, WIDTH*SEQ_W: per-lane sequence number.
- `err_mask`, output, 1: sticky flag for a non-contiguous lane mask.

## Operation
- **State:**
  - `pc` register: reset value `START_PC`.
  - `seq` register: reset value 1.
  - 2-entry output FIFO: reset value empty.
  - `err_mask`: reset value 0.
- **Accept:** a bundle is accepted when `in_valid && in_ready`.
- **Effective lane count `n`:** the number of leading ones in `in_lane_valid`, counted from lane 0. Lanes at or above the first zero are dropped, and their `out_lane_valid` bit is 0.
- **Mask error:** if any bit above the first zero is set, `err_mask` sets. It clears only on reset.
- **PC of lane i < n:** let j be the highest valid lane below i with `in_jump[j]=1`.
  - If j exists: `pc_i = result_j[ADDR_W-1:0] + INST_BYTES*(i-1-j)`.
  - Otherwise: `pc_i = pc + INST_BYTES*i`.
- **Next PC:** `next_pc` is the same formula evaluated at index n. If lane n-1 jumped, `next_pc = result_{n-1}`.
- **Sequence numbers:** `seq_i = seq + i`; `next_seq = seq + n`.
- **Arithmetic:** all additions are modulo `2^ADDR_W` or `2^SEQ_W`, with silent wrap.
- **On accept with n > 0:**
  - Push `{mask of n ones, pc_i, result_i, seq_i}` into the FIFO.
  - Load `pc <= next_pc` and `seq <= next_seq`.
- **On accept with n = 0:** the bundle is consumed. There is no push and no state change; `err_mask` still sets if the mask has a gap.
- **Resync:** `resync_valid` loads `pc <= resync_pc`; `seq` is unchanged.
  - If a bundle is accepted in the same cycle, it is reconstructed with the old `pc`, and `resync_pc` takes precedence over `next_pc`.
  - The FIFO contents are not flushed.
- **Non-valid lanes:** in an output entry, `out_pc`, `out_seq` and `out_result` for non-valid lanes are driven 0.

## Timing
- **Readiness:** `in_ready = !rst_active && fifo_count < 2`.
  - It is a function of registered state only; there is no combinational path from `out_ready`.
  - `in_ready` is 0 while `rst` is low. It rises in the first cycle after reset release.
- **Latency:** 1 cycle. A bundle accepted at edge k appears on `out_valid` and the data ports after edge k.
- **Throughput:** one bundle per cycle while `out_ready` is held at 1.
- **Output stall:** with `out_ready=0`, two bundles are absorbed, then `in_ready` drops. It rises in the cycle after the first pop.
- **Full FIFO with a same-cycle pop:** no push is possible in that cycle, because `in_ready` was 0.
- **Empty FIFO with a same-cycle push:** the count becomes 1; there is no bypass to the outputs.
- **Output stability:** the head entry holds stable while `out_valid && !out_ready`.
- **Reset values:**
  - `out_valid=0`, `in_ready=0`, `err_mask=0`.
  - `out_lane_valid`, `out_pc`, `out_result` and `out_seq` are all 0.
- **Mid-operation reset:** asserting `rst` asynchronously empties the FIFO and discards in-flight bundles. `pc`, `seq` and `err_mask` return to their reset values.

## Test plan
- **Sequential bundle:** reset, `START_PC=0x1000`, `WIDTH=4`, bundle mask 1111 with no jumps.
  - Required: `out_pc` = 0x1000/1004/1008/100C and `out_seq` = 1/2/3/4.
  - Required: the next bundle starts at 0x1010 with seq 5.
- **Jumps:** mask 1111, jump on lanes 0 and 2, `result0=0x2000`, `result2=0x3000`.
  - Required: pcs = 0x1000/2000/2004/3000, and the next PC is 0x3004.
- **Partial mask:** mask 0011 with jump on lane 1, `result1=0x4000`.
  - Required: `out_lane_valid=0011`, next PC 0x4000, seq advances by 2.
  - Follow-up: mask 0101 yields only lane 0, sets `err_mask`, and PC advances by 4.
- **Back-pressure:** hold `out_ready=0`, push 3 bundles.
  - Required: `in_ready` falls after 2 accepts, and the third waits.
  - Release: `out_ready=1` drains the entries in order with no loss or duplication.
  - Required: the third bundle is accepted 1 cycle after the first pop.
- **Resync:** `resync_valid` with `resync_pc=0x8000` in the same cycle as accepting a 4-lane no-jump bundle at PC 0x1000.
  - Required: that bundle shows 0x1000..0x100C.
  - Required: the next bundle starts at 0x8000 with seq continuing.
- **Wrap and mid-operation reset:**
  - PC wraps: 0xFFFF_FFF8 gives pcs FFFF_FFF8/FFFF_FFFC/0/4.
  - Asserting `rst` with a full FIFO: `out_valid` drops immediately, and after release the PC is `START_PC` and seq is 1.
